// File: rtl/data_island_packet_serializer_if.sv
// Picker <-> serializer bus: start/count and packet contents in,
// enable, pixel position, island flag and serialized bits out.
interface data_island_packet_serializer_if;
    logic             island_start;
    logic [4:0]       packet_count;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             packet_enable;
    logic [4:0]       packet_pixel_counter;
    logic             data_island_period;
    logic [8:0]       packet_data;

    // Source side (picker / island scheduler)
    modport master (
        output island_start, packet_count, header, sub,
        input  packet_enable, packet_pixel_counter, data_island_period, packet_data
    );

    // Serializer side
    modport slave (
        input  island_start, packet_count, header, sub,
        output packet_enable, packet_pixel_counter, data_island_period, packet_data
    );
endinterface

// File: rtl/data_island_packet_serializer.sv
// HDMI data-island packet serializer: sequences an island of up to
// MAX_PACKETS packets, 32 pixels each, streaming header and subpacket
// bits with BCH parity (G(x) = 1 + x^6 + x^7 + x^8) computed bit-serially.
module data_island_packet_serializer #(
    parameter int MAX_PACKETS = 18
) (
    input  logic                           clk_pixel,
    input  logic                           reset_n,
    data_island_packet_serializer_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [4:0]       counter, remaining, count_clamped;
    logic             start_ok, last_pix, active, pe;
    logic [23:0]      hdr_q, hdr_cur;
    logic [3:0][55:0] sub_q, sub_cur;
    logic [7:0]       ecc_h, seed_h;
    logic [3:0][7:0]  ecc_s, seed_s;
    logic [31:0]      hdr_stream;
    logic [3:0][63:0] sub_stream;
    logic             hdr_bit;
    logic [3:0]       even_bit, odd_bit;

    // One LFSR step of the BCH parity for data bit d.
    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic d);
        return {1'b0, e[7:1]} ^ ({8{d ^ e[0]}} & 8'h83);
    endfunction

    assign active        = (state == ACTIVE);
    assign start_ok      = bus.island_start && (bus.packet_count != 5'd0);
    assign last_pix      = (counter == 5'd31);
    assign count_clamped = (bus.packet_count > 5'(MAX_PACKETS)) ? 5'(MAX_PACKETS)
                                                                : bus.packet_count;

    // State register
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and picker advance request
    always_comb begin
        state_nxt = state;
        pe        = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = ACTIVE;
                    pe        = 1'b1;
                end
            end
            ACTIVE: begin
                if (last_pix) begin
                    if (remaining > 5'd1) pe = 1'b1;
                    else                  state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel counter free-runs while active (31 wraps to 0 between packets);
    // remaining packets loaded on start and consumed at each pixel 31.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= 5'd0;
            remaining <= 5'd0;
        end else if (!active) begin
            counter <= 5'd0;
            if (start_ok) remaining <= count_clamped;
        end else begin
            counter <= counter + 5'd1;
            if (last_pix) remaining <= remaining - 5'd1;
        end
    end

    // Bit selection: pixel 0 reads the live picker outputs, later pixels
    // the captured copy; parity sits above the data so one index covers both.
    always_comb begin
        hdr_cur    = (counter == 5'd0) ? bus.header : hdr_q;
        sub_cur    = (counter == 5'd0) ? bus.sub    : sub_q;
        seed_h     = (counter == 5'd0) ? 8'h00      : ecc_h;
        hdr_stream = {ecc_h, hdr_cur};
        hdr_bit    = hdr_stream[counter];
        for (int i = 0; i < 4; i++) begin
            seed_s[i]     = (counter == 5'd0) ? 8'h00 : ecc_s[i];
            sub_stream[i] = {ecc_s[i], sub_cur[i]};
            even_bit[i]   = sub_stream[i][{counter, 1'b0}];
            odd_bit[i]    = sub_stream[i][{counter, 1'b1}];
        end
    end

    // Packet capture and parity accumulation; parity freezes once data ends.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q <= '0;
            sub_q <= '0;
            ecc_h <= '0;
            ecc_s <= '0;
        end else if (active) begin
            if (counter == 5'd0) begin
                hdr_q <= bus.header;
                sub_q <= bus.sub;
            end
            if (counter < 5'd24) ecc_h <= bch_step(seed_h, hdr_bit);
            if (counter < 5'd28) begin
                for (int i = 0; i < 4; i++)
                    ecc_s[i] <= bch_step(bch_step(seed_s[i], even_bit[i]), odd_bit[i]);
            end
        end
    end

    assign bus.packet_enable        = pe;
    assign bus.packet_pixel_counter = counter;
    assign bus.data_island_period   = active;
    assign bus.packet_data          = active ? {odd_bit, even_bit, hdr_bit} : 9'd0;
endmodule

// File: doc/data_island_packet_serializer.md
# data_island_packet_serializer

Serializes HDMI data-island packets for the TMDS data-island encoder. It sits directly downstream of the packet picker: it sequences the island, pulses `packet_enable` so the picker selects the next packet, and streams each 24-bit header and four 56-bit subpackets over 32 pixel clocks. It appends BCH parity computed bit-serially on the fly.

## Interface
- `MAX_PACKETS`, default 18: maximum packets per island; larger requests are clamped to this value.
- `clk_pixel` in 1: pixel clock; all state is clocked on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `island_start` in 1: one-cycle pulse in the cycle before pixel 0 of the first packet.
- `packet_count` in 5: number of packets in the island; sampled on an accepted `island_start`.
- `header` in 24: header from the picker; must be valid from pixel 0 of each packet.
- `sub` in 4x56: subpackets 0..3 from the picker; same validity as `header`.
- `packet_enable` out 1: asks the picker to advance; the picker's outputs change on the following edge.
- `packet_pixel_counter` out 5: pixel index within the current packet, 0..31.
- `data_island_period` out 1: high for every pixel of the island.
- `packet_data` out 9:
  - [0] = header bit.
  - [4:1] = even bit of sub[3:0].
  - [8:5] = odd bit of sub[3:0].

## Operation
- States:
  - IDLE → ACTIVE on `island_start` when `packet_count` != 0.
  - ACTIVE → IDLE after pixel 31 of the last packet.
- Starts while ACTIVE are ignored. A start with `packet_count` == 0 is ignored. A `packet_count` above `MAX_PACKETS` is loaded as `MAX_PACKETS`.
- `remaining` register: loaded on start, decremented at each pixel 31.
- `packet_enable` (combinational) = (IDLE & accepted start) | (ACTIVE & counter == 31 & `remaining` > 1).
- Capture at pixel 0:
  - `header` and `sub` are registered.
  - Pixel 0 itself uses the live inputs; pixels 1..31 use the registered copy.
- BCH step, one data bit `d` into 8-bit `e`: e' = {0, e[7:1]} XOR ({8{d ^ e[0]}} AND 8'h83). This is G(x) = 1 + x^6 + x^7 + x^8.
- Header path:
  - Pixels 0..23 emit header bit n and step the header ECC, seeded with 0 at pixel 0.
  - Pixels 24..31 emit ecc_h[n-24] from the frozen final value.
- Subpacket path, one ECC per subpacket:
  - Pixels 0..27 emit bits 2n (even) and 2n+1 (odd). ECC steps twice per cycle, bit 2n first. Seeded with 0 at pixel 0.
  - Pixels 28..31 emit ecc_s[2(n-28)] (even) and ecc_s[2(n-28)+1] (odd).
- Outside ACTIVE, `packet_data` = 0.

## Timing
- Reset values: state IDLE; `packet_pixel_counter` 0; `data_island_period` 0; `packet_enable` 0; `packet_data` 0; `remaining` 0; ECC registers 0.
- Reset assertion mid-island clears everything immediately, with no completion of the current packet.
- Start accepted at cycle T:
  - Pixel 0 of packet 0 is at T+1.
  - `data_island_period` is high for T+1 .. T+32·count inclusive, then low.
- `packet_pixel_counter` is registered. It wraps 31→0 between back-to-back packets with no gap cycle.
- `packet_data` for pixel n is valid in the same cycle that the counter equals n (zero added latency).
- A start pulse in the final pixel of an island (counter 31, `remaining` == 1) is ignored.

## Test plan
- Reset, then start with count=1, `header`=24'h000001, all subs 0:
  - `packet_enable` high only in the start cycle.
  - `data_island_period` high for exactly 32 cycles.
  - `packet_data[0]` = 1 at pixel 0, 0 at pixels 1..23.
  - Pixels 24..31 carry 0x4A LSB-first: 0,1,0,1,0,0,1,0.
  - `packet_data[8:1]` = 0 throughout.
- Count=3, picker model changing packet type on each `packet_enable`:
  - Enables at T and at pixel 31 of packets 0 and 1 only.
  - Counter runs 0..31 three times with no gap.
  - 96 active cycles.
- Random headers and subs, 1000 packets: every emitted 32-bit header stream and 64-bit subpacket stream matches a bit-serial BCH golden model.
- `island_start` pulsed mid-island, and again at the last pixel: ignored, with island length unchanged. `packet_count`=0 start: no activity. `packet_count`=25: 18 packets.
- Assert `reset_n` at pixel 13 of packet 1:
  - All outputs are 0 in the same cycle.
  - After release, a new start yields a clean island from pixel 0 with ECC seeded at 0.
